// File: rtl/project_stream_unit.sv
// Sequential triangle projector: 4x4 MVP transform on one time-shared row dot product,
// restoring-divider perspective divide, clip test and viewport mapping, one triangle in flight.
//
// state    | meaning
// S_IDLE   | ready for a triangle, matrix may be reloaded
// S_XFORM  | one matrix row per cycle for the current vertex (4 cycles)
// S_DIVIDE | parallel x/y restoring division by Wc (WI+WF cycles)
// S_VIEW   | viewport map and store screen coordinates of the current vertex
// S_DONE   | result valid, held until the sink takes it
module project_stream_unit #(
  parameter int WI     = 8,
  parameter int WF     = 8,
  parameter int SW     = 10,
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [16*(WI+WF)-1:0] mvp_in,
  input  logic                  mvp_load,
  input  logic                  tri_valid,
  output logic                  tri_ready,
  input  logic [9*(WI+WF)-1:0]  tri_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [6*SW-1:0]       proj_triangle,
  output logic                  clip,
  output logic                  busy
);

  localparam int W  = WI + WF;
  localparam int AW = 2*W + 2;
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [W-1:0]         ONE_W   = {{(WI-1){1'b0}}, 1'b1, {WF{1'b0}}};
  localparam logic signed [W-1:0]  MAX_W   = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0]  MIN_W   = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [AW-1:0] ACC_MAX = {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [AW-1:0] ACC_MIN = {{(AW-W+1){1'b1}}, {(W-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_XFORM, S_DIVIDE, S_VIEW, S_DONE} state_t;

  function automatic logic signed [AW-1:0] sext_acc(input logic [W-1:0] a);
    return $signed({{(AW-W){a[W-1]}}, a});
  endfunction

  function automatic logic signed [W-1:0] sat_acc(input logic signed [AW-1:0] a);
    if (a > ACC_MAX) return MAX_W;
    else if (a < ACC_MIN) return MIN_W;
    else return a[W-1:0];
  endfunction

  function automatic logic [W:0] mag(input logic [W-1:0] a);
    return a[W-1] ? ({1'b0, ~a} + 1'b1) : {1'b0, a};
  endfunction

  function automatic logic signed [W-1:0] q_sat(input logic ovf, input logic neg,
                                                input logic [W-1:0] q);
    if (!neg) return (ovf || q[W-1]) ? MAX_W : $signed(q);
    else if (ovf || (q[W-1] && (|q[W-2:0]))) return MIN_W;
    else return $signed(~q + 1'b1);
  endfunction

  function automatic logic [SW-1:0] to_screen(input int v, input int lim);
    if (v < 0) return '0;
    else if (v > lim) return SW'(lim);
    else return SW'(v);
  endfunction

  state_t              state_q, state_d;
  logic [W-1:0]        mtx_q [16];
  logic [W-1:0]        mtx_d [16];
  logic [W-1:0]        vtx_q [9];
  logic [W-1:0]        vtx_d [9];
  logic [1:0]          vidx_q, vidx_d, row_q, row_d;
  logic signed [W-1:0] xc_q, xc_d, yc_q, yc_d, zc_q, zc_d, wc_q, wc_d;
  logic                wpos_q, wpos_d, xneg_q, xneg_d, yneg_q, yneg_d;
  logic                xovf_q, xovf_d, yovf_q, yovf_d;
  logic [W-1:0]        xrem_q, xrem_d, yrem_q, yrem_d;
  logic [W-1:0]        xlo_q, xlo_d, ylo_q, ylo_d;
  logic [W-1:0]        xquo_q, xquo_d, yquo_q, yquo_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [SW-1:0]       proj_q [6];
  logic [SW-1:0]       proj_d [6];
  logic                out_valid_q, out_valid_d, clip_q, clip_d;
  logic                tri_ready_q, tri_ready_d, busy_q, busy_d;

  logic signed [AW-1:0] acc;
  logic signed [W-1:0]  row_val, qx, qy;
  logic [3:0]           midx, vidx;
  logic                 wc_pos, clip_v, xge, yge;
  logic [W+WF:0]        xdvd, ydvd;
  logic [W-1:0]         xrem0, yrem0, xdiff, ydiff;
  int                   sxv, syv;

  always_comb begin
    state_d     = state_q;
    mtx_d       = mtx_q;
    vtx_d       = vtx_q;
    vidx_d      = vidx_q;
    row_d       = row_q;
    xc_d        = xc_q;
    yc_d        = yc_q;
    zc_d        = zc_q;
    wc_d        = wc_q;
    wpos_d      = wpos_q;
    xneg_d      = xneg_q;
    yneg_d      = yneg_q;
    xovf_d      = xovf_q;
    yovf_d      = yovf_q;
    xrem_d      = xrem_q;
    yrem_d      = yrem_q;
    xlo_d       = xlo_q;
    ylo_d       = ylo_q;
    xquo_d      = xquo_q;
    yquo_d      = yquo_q;
    cnt_d       = cnt_q;
    proj_d      = proj_q;
    out_valid_d = out_valid_q;
    clip_d      = clip_q;
    tri_ready_d = tri_ready_q;

    // Row dot product; the implied w=1.0 term is the column-3 entry shifted up.
    midx = {row_q, 2'd3};
    acc  = sext_acc(mtx_q[midx]) <<< WF;
    vidx = {2'b0, vidx_q} + {1'b0, vidx_q, 1'b0};
    for (int c = 0; c < 3; c++) begin
      midx = {row_q, 2'(c)};
      acc  = acc + sext_acc(mtx_q[midx]) * sext_acc(vtx_q[vidx + 4'(c)]);
    end
    row_val = sat_acc(acc >>> WF);

    wc_pos = !row_val[W-1] && (|row_val);
    clip_v = !wc_pos || (mag(xc_q) > {1'b0, row_val}) || (mag(yc_q) > {1'b0, row_val}) ||
             (mag(zc_q) > {1'b0, row_val});

    // Dividend is |coord|<<WF; its bits above W seed the remainder, the rest shift in.
    xdvd  = {mag(xc_q), {WF{1'b0}}};
    ydvd  = {mag(yc_q), {WF{1'b0}}};
    xrem0 = {{(W-WF-1){1'b0}}, xdvd[W+WF:W]};
    yrem0 = {{(W-WF-1){1'b0}}, ydvd[W+WF:W]};
    xge   = {xrem_q, xlo_q[W-1]} >= {1'b0, wc_q};
    yge   = {yrem_q, ylo_q[W-1]} >= {1'b0, wc_q};
    xdiff = {xrem_q[W-2:0], xlo_q[W-1]} - wc_q;
    ydiff = {yrem_q[W-2:0], ylo_q[W-1]} - wc_q;

    qx  = wpos_q ? q_sat(xovf_q, xneg_q, xquo_q) : '0;
    qy  = wpos_q ? q_sat(yovf_q, yneg_q, yquo_q) : '0;
    sxv = ((int'(qx) + int'(ONE_W)) * WIDTH) >>> (WF + 1);
    syv = ((int'(ONE_W) - int'(qy)) * HEIGHT) >>> (WF + 1);

    case (state_q)
      S_IDLE: begin
        tri_ready_d = 1'b1;
        if (mvp_load) begin
          for (int i = 0; i < 16; i++) mtx_d[i] = mvp_in[i*W +: W];
        end
        if (tri_valid && tri_ready_q) begin
          for (int k = 0; k < 9; k++) vtx_d[k] = tri_in[k*W +: W];
          vidx_d      = 2'd0;
          row_d       = 2'd0;
          clip_d      = 1'b0;
          tri_ready_d = 1'b0;
          state_d     = S_XFORM;
        end
      end
      S_XFORM: begin
        case (row_q)
          2'd0: xc_d = row_val;
          2'd1: yc_d = row_val;
          2'd2: zc_d = row_val;
          default: begin
            wc_d    = row_val;
            wpos_d  = wc_pos;
            clip_d  = clip_q | clip_v;
            xneg_d  = xc_q[W-1];
            yneg_d  = yc_q[W-1];
            xovf_d  = xrem0 >= row_val;
            yovf_d  = yrem0 >= row_val;
            xrem_d  = xrem0;
            yrem_d  = yrem0;
            xlo_d   = xdvd[W-1:0];
            ylo_d   = ydvd[W-1:0];
            xquo_d  = '0;
            yquo_d  = '0;
            cnt_d   = CW'(W - 1);
            state_d = S_DIVIDE;
          end
        endcase
        row_d = row_q + 2'd1;
      end
      S_DIVIDE: begin
        if (xge) xrem_d = xdiff;
        else     xrem_d = {xrem_q[W-2:0], xlo_q[W-1]};
        if (yge) yrem_d = ydiff;
        else     yrem_d = {yrem_q[W-2:0], ylo_q[W-1]};
        xquo_d = {xquo_q[W-2:0], xge};
        yquo_d = {yquo_q[W-2:0], yge};
        xlo_d  = xlo_q << 1;
        ylo_d  = ylo_q << 1;
        if (cnt_q == '0) state_d = S_VIEW;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_VIEW: begin
        proj_d[{vidx_q, 1'b0}] = to_screen(sxv, WIDTH - 1);
        proj_d[{vidx_q, 1'b1}] = to_screen(syv, HEIGHT - 1);
        if (vidx_q == 2'd2) begin
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          vidx_d  = vidx_q + 2'd1;
          state_d = S_XFORM;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          tri_ready_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      for (int i = 0; i < 16; i++) mtx_q[i] <= (i % 5 == 0) ? ONE_W : '0;
      for (int k = 0; k < 9; k++) vtx_q[k] <= '0;
      for (int p = 0; p < 6; p++) proj_q[p] <= '0;
      vidx_q      <= '0;
      row_q       <= '0;
      xc_q        <= '0;
      yc_q        <= '0;
      zc_q        <= '0;
      wc_q        <= '0;
      wpos_q      <= 1'b0;
      xneg_q      <= 1'b0;
      yneg_q      <= 1'b0;
      xovf_q      <= 1'b0;
      yovf_q      <= 1'b0;
      xrem_q      <= '0;
      yrem_q      <= '0;
      xlo_q       <= '0;
      ylo_q       <= '0;
      xquo_q      <= '0;
      yquo_q      <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      clip_q      <= 1'b0;
      tri_ready_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mtx_q       <= mtx_d;
      vtx_q       <= vtx_d;
      proj_q      <= proj_d;
      vidx_q      <= vidx_d;
      row_q       <= row_d;
      xc_q        <= xc_d;
      yc_q        <= yc_d;
      zc_q        <= zc_d;
      wc_q        <= wc_d;
      wpos_q      <= wpos_d;
      xneg_q      <= xneg_d;
      yneg_q      <= yneg_d;
      xovf_q      <= xovf_d;
      yovf_q      <= yovf_d;
      xrem_q      <= xrem_d;
      yrem_q      <= yrem_d;
      xlo_q       <= xlo_d;
      ylo_q       <= ylo_d;
      xquo_q      <= xquo_d;
      yquo_q      <= yquo_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      clip_q      <= clip_d;
      tri_ready_q <= tri_ready_d;
      busy_q      <= busy_d;
    end
  end

  for (genvar g = 0; g < 6; g++) begin : g_proj
    assign proj_triangle[g*SW +: SW] = proj_q[g];
  end

  assign tri_ready = tri_ready_q;
  assign out_valid = out_valid_q;
  assign clip      = clip_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_project_stream_unit.sv
// Bench for project_stream_unit: directed corner cases plus random triangles checked
// against a plain-arithmetic projection model.
module tb_project_stream_unit;
  localparam int W  = 16;
  localparam int SW = 10;

  logic            clk = 1'b0;
  logic            reset;
  logic [16*W-1:0] mvp_in;
  logic            mvp_load;
  logic            tri_valid;
  logic            tri_ready;
  logic [9*W-1:0]  tri_in;
  logic            out_valid;
  logic            out_ready;
  logic [6*SW-1:0] proj_triangle;
  logic            clip;
  logic            busy;

  project_stream_unit dut (
    .Clk(clk), .Reset(reset), .mvp_in(mvp_in), .mvp_load(mvp_load),
    .tri_valid(tri_valid), .tri_ready(tri_ready), .tri_in(tri_in),
    .out_valid(out_valid), .out_ready(out_ready), .proj_triangle(proj_triangle),
    .clip(clip), .busy(busy)
  );

  always #5 clk = ~clk;

  int     n_checks = 0;
  int     n_fail   = 0;
  longint m_mod [16];
  longint cur_m [16];
  longint v_mod [9];
  longint exp_sx [3];
  longint exp_sy [3];
  bit     exp_clip;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint sat16(input longint a);
    if (a > 32767) return 32767;
    if (a < -32768) return -32768;
    return a;
  endfunction

  function automatic longint clampl(input longint a, input longint lo, input longint hi);
    if (a < lo) return lo;
    if (a > hi) return hi;
    return a;
  endfunction

  function automatic longint labs(input longint a);
    return (a < 0) ? -a : a;
  endfunction

  function automatic longint rnd(input int lo, input int hi);
    return longint'(lo) + longint'($urandom_range(hi - lo));
  endfunction

  // Projection of the current triangle under the matrix the DUT should be using.
  task automatic model_run();
    longint vv [4];
    longint r [4];
    longint acc, qx, qy;
    exp_clip = 0;
    for (int v = 0; v < 3; v++) begin
      vv[0] = v_mod[3*v]; vv[1] = v_mod[3*v+1]; vv[2] = v_mod[3*v+2]; vv[3] = 256;
      for (int rr = 0; rr < 4; rr++) begin
        acc = 0;
        for (int c = 0; c < 4; c++) acc += cur_m[4*rr+c] * vv[c];
        r[rr] = sat16(acc >>> 8);
      end
      if (r[3] <= 0 || labs(r[0]) > r[3] || labs(r[1]) > r[3] || labs(r[2]) > r[3])
        exp_clip = 1;
      if (r[3] > 0) begin
        qx = sat16((r[0] * 256) / r[3]);
        qy = sat16((r[1] * 256) / r[3]);
      end else begin
        qx = 0;
        qy = 0;
      end
      exp_sx[v] = clampl(((qx + 256) * 640) >>> 9, 0, 639);
      exp_sy[v] = clampl(((256 - qy) * 480) >>> 9, 0, 479);
    end
  endtask

  task automatic set_identity();
    for (int i = 0; i < 16; i++) m_mod[i] = (i % 5 == 0) ? 256 : 0;
  endtask

  task automatic set_verts(input longint a0, a1, a2, b0, b1, b2, c0, c1, c2);
    v_mod[0] = a0; v_mod[1] = a1; v_mod[2] = a2;
    v_mod[3] = b0; v_mod[4] = b1; v_mod[5] = b2;
    v_mod[6] = c0; v_mod[7] = c1; v_mod[8] = c2;
  endtask

  task automatic rand_verts();
    for (int k = 0; k < 9; k++) v_mod[k] = rnd(-384, 384);
  endtask

  task automatic rand_mat(input bit wild);
    for (int i = 0; i < 16; i++) begin
      if (wild)        m_mod[i] = rnd(-512, 512);
      else if (i < 12) m_mod[i] = rnd(-300, 300);
      else if (i < 15) m_mod[i] = rnd(-64, 64);
      else             m_mod[i] = rnd(128, 512);
    end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < 16; i++) mvp_in[i*W +: W] = m_mod[i][15:0];
    for (int k = 0; k < 9; k++) tri_in[k*W +: W] = v_mod[k][15:0];
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    while (tri_ready !== 1'b1 && k < 200) begin
      tick();
      k++;
    end
    chk("tri_ready_wait", tri_ready, 1);
  endtask

  // One full transaction: accept, latency, result vs model, optional backpressure, release.
  task automatic send_tri(input bit load, input int hold, input bit glitch);
    int k;
    logic [6*SW-1:0] snap;
    logic snap_clip;
    wait_ready();
    if (load) for (int i = 0; i < 16; i++) cur_m[i] = m_mod[i];
    drive_inputs();
    model_run();
    tri_valid = 1'b1;
    mvp_load  = load;
    out_ready = (hold == 0);
    tick();
    tri_valid = 1'b0;
    mvp_load  = 1'b0;
    chk("busy_after_accept", busy, 1);
    k = 0;
    while (out_valid !== 1'b1 && k < 200) begin
      tick();
      k++;
      if (glitch && k == 8) begin
        for (int i = 0; i < 16; i++) mvp_in[i*W +: W] = 16'($urandom);
        mvp_load = 1'b1;
      end
      if (glitch && k == 9) mvp_load = 1'b0;
    end
    chk("latency", k, 63);
    for (int v = 0; v < 3; v++) begin
      chk($sformatf("v%0d_sx", v), proj_triangle[(2*v)*SW +: SW], exp_sx[v]);
      chk($sformatf("v%0d_sy", v), proj_triangle[(2*v+1)*SW +: SW], exp_sy[v]);
    end
    chk("clip", clip, exp_clip);
    if (hold > 0) begin
      snap      = proj_triangle;
      snap_clip = clip;
      tri_valid = 1'b1;
      for (int kk = 0; kk < 9; kk++) tri_in[kk*W +: W] = 16'($urandom);
      for (int h = 0; h < hold; h++) begin
        tick();
        chk("hold_valid", out_valid, 1);
        chk("hold_tri_ready", tri_ready, 0);
        chk("hold_proj", proj_triangle, snap);
        chk("hold_clip", clip, snap_clip);
      end
      tri_valid = 1'b0;
      out_ready = 1'b1;
    end
    tick();
    out_ready = 1'b0;
    chk("valid_one_cycle", out_valid, 0);
    chk("tri_ready_after_done", tri_ready, 1);
  endtask

  initial begin
    int k, seen;
    reset     = 1'b1;
    mvp_in    = '0;
    mvp_load  = 1'b0;
    tri_valid = 1'b0;
    tri_in    = '0;
    out_ready = 1'b0;
    set_identity();
    for (int i = 0; i < 16; i++) cur_m[i] = m_mod[i];
    repeat (3) tick();
    chk("rst_tri_ready", tri_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_proj", proj_triangle, 0);
    chk("rst_clip", clip, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    tick();
    chk("tri_ready_after_reset", tri_ready, 1);

    // Reset-time identity matrix, corner vertices.
    set_verts(0, 0, 0, 256, 256, 0, -256, -256, 0);
    send_tri(0, 0, 0);
    chk("t1_v0x", proj_triangle[0*SW +: SW], 320);
    chk("t1_v0y", proj_triangle[1*SW +: SW], 240);
    chk("t1_v1x", proj_triangle[2*SW +: SW], 639);
    chk("t1_v1y", proj_triangle[3*SW +: SW], 0);
    chk("t1_v2x", proj_triangle[4*SW +: SW], 0);
    chk("t1_v2y", proj_triangle[5*SW +: SW], 479);
    chk("t1_clip", clip, 0);

    // Perspective: w taken from z.
    set_identity();
    m_mod[12] = 0; m_mod[13] = 0; m_mod[14] = 256; m_mod[15] = 0;
    set_verts(256, 128, 512, 256, 128, 512, 256, 128, 512);
    send_tri(1, 0, 0);
    chk("t3_sx", proj_triangle[0*SW +: SW], 480);
    chk("t3_sy", proj_triangle[1*SW +: SW], 180);
    chk("t3_clip", clip, 0);

    // Clip: x outside the frustum, then w forced to zero.
    set_identity();
    set_verts(512, 0, 0, 0, 0, 0, 0, 0, 0);
    send_tri(1, 0, 0);
    chk("t4a_clip", clip, 1);
    chk("t4a_sx", proj_triangle[0*SW +: SW], 639);
    for (int i = 12; i < 16; i++) m_mod[i] = 0;
    set_verts(0, 0, 0, 0, 0, 0, 0, 0, 0);
    send_tri(1, 0, 0);
    chk("t4b_clip", clip, 1);
    chk("t4b_sx", proj_triangle[0*SW +: SW], 320);
    chk("t4b_sy", proj_triangle[1*SW +: SW], 240);

    // Backpressure with a competing tri_valid.
    set_identity();
    rand_verts();
    send_tri(1, 10, 0);

    // Abort mid-triangle with Reset, matrix returns to identity.
    rand_mat(0);
    rand_verts();
    send_tri(1, 0, 0);
    rand_verts();
    wait_ready();
    drive_inputs();
    tri_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    tri_valid = 1'b0;
    repeat (22) tick();
    reset = 1'b1;
    tick();
    chk("abort_tri_ready", tri_ready, 0);
    chk("abort_busy", busy, 0);
    chk("abort_out_valid", out_valid, 0);
    tick();
    reset = 1'b0;
    chk("abort_tri_ready_low", tri_ready, 0);
    tick();
    chk("abort_tri_ready_1cyc", tri_ready, 1);
    seen = 0;
    for (k = 0; k < 80; k++) begin
      tick();
      if (out_valid === 1'b1) seen++;
    end
    chk("abort_no_output", seen, 0);
    out_ready = 1'b0;
    set_identity();
    for (int i = 0; i < 16; i++) cur_m[i] = m_mod[i];
    rand_verts();
    send_tri(0, 0, 1);
    rand_verts();
    send_tri(0, 0, 0);

    // Random triangles and matrices.
    for (int it = 0; it < 20; it++) begin
      rand_mat(it % 4 == 3);
      rand_verts();
      send_tri((it % 3 != 2), (it % 2 == 1) ? int'(rnd(1, 5)) : 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

endmodule
